esn_readout: RTL and testbench
==============================

// Module: esn_readout
// PURPOSE
// - Linear readout stage directly downstream of the reservoir top.
// - Consumes the 8-word state bus {U, x6..x0} and its 6-bit sample address.
// - Computes y = sum_k WOUT[k]*X[k] in signed fixed point, then rounds and saturates to 16 bits.
// - Emits y with a 1-cycle valid strobe, the matching sample address and a sticky overrun flag.
// PARAMETERS
// - WORD_W     16            width of each state/weight word, signed two's complement
// - N_WORDS    8             words on the state bus: 7 neurons plus input U
// - ADDR_W     6             sample address width
// - FRAC_BITS  12            fractional bits of X, WOUT and Y (Q3.12); must be >= 1
// - LANES      4             multipliers used per MAC cycle, from {1,2,4,8}; MAC cycles = N_WORDS/LANES
// - WOUT       128'h0        readout weights; word k = WOUT[16k+15:16k]
// PORTS
// - clk        in   1    single clock
// - rst_N      in   1    asynchronous reset, active low
// - XSTATE     in   128  word k = XSTATE[16k+15:16k]; k=0..6 are neuron states, k=7 is input U
// - ADDR_IN    in   6    sample address travelling with XSTATE
// - Y          out  16   readout result, signed Q3.12
// - Y_VALID    out  1    1-cycle pulse; Y and Y_ADDR are valid while it is high
// - Y_ADDR     out  6    address of the sample that produced Y
// - OVERRUN    out  1    sticky; set when a sample arrives while a MAC is in progress
// BEHAVIOUR
// - Reset:
//   - Y, Y_VALID, Y_ADDR and OVERRUN are 0.
//   - addr_prev = 0, acc = 0, FSM = IDLE.
//   - All registers clear asynchronously.
// - New-sample detect: new = (ADDR_IN != addr_prev). addr_prev <= ADDR_IN every cycle.
//   - The wrap from 63 to 0 counts as a change.
//   - Address 0 held after reset does not trigger a capture.
// - FSM states:
//   - IDLE: if new, capture XSTATE into xs_r and ADDR_IN into addr_r, clear acc, idx=0, go to MAC.
//   - MAC: acc += sum of LANES products for words idx*LANES .. idx*LANES+LANES-1.
//     - idx++ each cycle; after N_WORDS/LANES cycles go to OUT.
//     - A new sample during MAC sets OVERRUN and is dropped; the current MAC continues.
//   - OUT: Y <= sat16(rnd(acc)), Y_ADDR <= addr_r, Y_VALID <= 1 (high in the next cycle).
//     - If new in this same cycle, capture and go to MAC (back-to-back); otherwise go to IDLE.
// - Latency, default LANES=4: capture in cycle 0, MAC in cycles 1-2, OUT in cycle 3, Y_VALID high in cycle 4.
//   - Throughput is one sample per 4 cycles, which matches the upstream address rate.
// - Arithmetic:
//   - Products are 16x16 signed, 32 bits wide.
//   - acc is 35 bits (32 + log2 N_WORDS); it cannot overflow.
//   - rnd: (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, i.e. round half toward +inf.
//   - sat16: clamp to the range 0x8000 .. 0x7FFF.
// - Y and Y_ADDR hold their value between strobes.
// - OVERRUN clears only on reset.
// - Reset mid-operation aborts the MAC; no Y_VALID is produced for the aborted sample.
// STRUCTURE
// - esn_pkg holds:
//   - constants WORD_W, N_WORDS, ADDR_W and ACC_W=35;
//   - localparam state codes IDLE=2'd0, MAC=2'd1, OUT=2'd2.
// - One sub-module, esn_round_sat: parameterised FRAC_BITS; combinational 35-bit acc in, 16-bit Y out.
// - The top holds the FSM, snapshot registers, the LANES-wide multiply-add tree and the output registers.
// TESTING
// - Reset: hold rst_N=0 with random XSTATE and ADDR_IN -> Y=0, Y_VALID=0, Y_ADDR=0, OVERRUN=0; no capture after release while ADDR_IN stays 0.
// - Basic MAC: WOUT words all 0x1000, XSTATE words all 0x0100, ADDR_IN 0->1 in cycle 0 -> Y_VALID high only in cycle 4, Y=0x0800, Y_ADDR=1.
// - Rounding: X0=0x0001, all other X=0, W0=0x0800 -> Y=0x0001; with W0=0x07FF -> Y=0x0000.
// - Saturation: all X=0x7FFF and all W=0x7FFF -> Y=0x7FFF; all X=0x8000 and all W=0x7FFF -> Y=0x8000.
// - Stream and overrun:
//   - Address steps every 4 cycles through 62, 63, 0 -> one strobe per sample, Y_ADDR=0 follows 63, OVERRUN stays 0.
//   - Address steps at cycles 0 and 2 -> OVERRUN=1, one strobe only, Y_ADDR = first address.
// - Reset mid-MAC: rst_N=0 in cycle 1 of a MAC -> no Y_VALID, all outputs 0, OVERRUN cleared.

Source files
------------

// File: rtl/esn_pkg.sv
// Shared constants and FSM state codes for the ESN linear readout.
package esn_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned N_WORDS = 8;
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned ACC_W   = 35;
    localparam int unsigned PROD_W  = 2 * WORD_W;
    localparam int unsigned BUS_W   = WORD_W * N_WORDS;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t MAC  = 2'd1;
    localparam state_t OUT  = 2'd2;

endpackage

// File: rtl/esn_round_sat.sv
// Round-half-up of the Q-format accumulator followed by saturation to a signed 16-bit word.
module esn_round_sat
    import esn_pkg::*;
#(
    parameter int unsigned FRAC_BITS = 12
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [WORD_W-1:0] y_c
);

    localparam logic signed [ACC_W:0] HALF  = (ACC_W+1)'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_W:0] Y_MAX = {{(ACC_W+1-WORD_W){1'b0}}, 1'b0, {(WORD_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] Y_MIN = {{(ACC_W+1-WORD_W){1'b1}}, 1'b1, {(WORD_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_c;
    logic signed [ACC_W:0] shf_c;

    // One guard bit keeps the rounding add from wrapping at the accumulator extremes.
    always_comb begin
        sum_c = $signed({acc_i[ACC_W-1], acc_i}) + HALF;
        shf_c = sum_c >>> FRAC_BITS;
        if (shf_c > Y_MAX) begin
            y_c = Y_MAX[WORD_W-1:0];
        end else if (shf_c < Y_MIN) begin
            y_c = Y_MIN[WORD_W-1:0];
        end else begin
            y_c = shf_c[WORD_W-1:0];
        end
    end

endmodule

// File: rtl/esn_readout.sv
// Linear readout y = sum WOUT[k]*X[k] over the reservoir state bus, LANES products per MAC cycle.
module esn_readout
    import esn_pkg::*;
#(
    parameter int unsigned      FRAC_BITS = 12,
    parameter int unsigned      LANES     = 4,
    parameter logic [BUS_W-1:0] WOUT      = '0
) (
    input  logic              clk,
    input  logic              rst_N,
    input  logic [BUS_W-1:0]  XSTATE,
    input  logic [ADDR_W-1:0] ADDR_IN,
    output logic [WORD_W-1:0] Y,
    output logic              Y_VALID,
    output logic [ADDR_W-1:0] Y_ADDR,
    output logic              OVERRUN
);

    localparam int unsigned N_STEPS = N_WORDS / LANES;
    localparam int unsigned IDX_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STEPS - 1);

    state_t                    state_q;
    logic [ADDR_W-1:0]         addr_prev_q;
    logic [BUS_W-1:0]          xs_q;
    logic [ADDR_W-1:0]         addr_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [IDX_W-1:0]          idx_q;
    logic [WORD_W-1:0]         y_q;
    logic                      y_valid_q;
    logic [ADDR_W-1:0]         y_addr_q;
    logic                      ovr_q;

    logic                      new_c;
    logic signed [PROD_W-1:0]  prod_c [LANES];
    logic signed [ACC_W-1:0]   lane_sum_c;
    logic signed [WORD_W-1:0]  y_rs_c;

    assign new_c = (ADDR_IN != addr_prev_q);

    // Multipliers for the words selected by the current MAC step.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            prod_c[l] = PROD_W'($signed(xs_q[(32'(idx_q) * LANES + 32'(l)) * WORD_W +: WORD_W]))
                      * PROD_W'($signed(WOUT[(32'(idx_q) * LANES + 32'(l)) * WORD_W +: WORD_W]));
        end
    end

    always_comb begin
        lane_sum_c = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum_c = lane_sum_c + ACC_W'(prod_c[l]);
        end
    end

    esn_round_sat #(
        .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
        .acc_i (acc_q),
        .y_c   (y_rs_c)
    );

    // Sequencer: capture a new sample, accumulate over N_STEPS cycles, then publish.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state_q     <= IDLE;
            addr_prev_q <= '0;
            xs_q        <= '0;
            addr_q      <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            y_addr_q    <= '0;
            ovr_q       <= 1'b0;
        end else begin
            addr_prev_q <= ADDR_IN;
            y_valid_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (new_c) begin
                        xs_q    <= XSTATE;
                        addr_q  <= ADDR_IN;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_q + lane_sum_c;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_q <= OUT;
                    end
                    if (new_c) begin
                        ovr_q <= 1'b1;
                    end
                end
                OUT: begin
                    y_q       <= y_rs_c;
                    y_addr_q  <= addr_q;
                    y_valid_q <= 1'b1;
                    if (new_c) begin
                        xs_q    <= XSTATE;
                        addr_q  <= ADDR_IN;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= MAC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Y       = y_q;
    assign Y_VALID = y_valid_q;
    assign Y_ADDR  = y_addr_q;
    assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_esn_readout.sv
// Scoreboard bench for esn_readout: four instances with different weight sets share one stimulus stream.
module tb_esn_readout;
    import esn_pkg::*;

    localparam int N_DUT = 4;

    function automatic logic [127:0] wsel(input int i);
        case (i)
            0:       return {8{16'h1000}};
            1:       return {16'h0123, 16'hFF00, 16'h0A0A, 16'hF234, 16'h0040, 16'hFFF0, 16'h2000, 16'h0800};
            2:       return {16'hE000, 16'h1111, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h0400, 16'h07FF};
            default: return {8{16'h7FFF}};
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rst_N = 1'b0;
    logic [127:0] xstate;
    logic [5:0]   addr_in;
    logic [15:0]  y_w   [N_DUT];
    logic         yv_w  [N_DUT];
    logic [5:0]   ya_w  [N_DUT];
    logic         ovr_w [N_DUT];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < N_DUT; g++) begin : g_dut
            esn_readout #(
                .FRAC_BITS (12),
                .LANES     (4),
                .WOUT      (wsel(g))
            ) u_dut (
                .clk     (clk),
                .rst_N   (rst_N),
                .XSTATE  (xstate),
                .ADDR_IN (addr_in),
                .Y       (y_w[g]),
                .Y_VALID (yv_w[g]),
                .Y_ADDR  (ya_w[g]),
                .OVERRUN (ovr_w[g])
            );
        end
    endgenerate

    typedef struct {
        logic [15:0] y;
        logic [5:0]  addr;
        int          due;
    } exp_t;

    exp_t       sb_q [N_DUT][$];
    exp_t       mon_e;
    int         cyc = 0;
    int         vectors = 0;
    int         ncmp = 0;
    int         nmis = 0;
    int         last_cap = -100;
    logic [5:0] prev = '0;
    bit         ovr_exp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact integer dot product, round half up at bit 12, clamp to 16-bit signed.
    function automatic logic [15:0] ref_y(input logic [127:0] w, input logic [127:0] x);
        longint acc = 0;
        longint r;
        for (int k = 0; k < 8; k++) begin
            acc += longint'($signed(w[16*k +: 16])) * longint'($signed(x[16*k +: 16]));
        end
        r = (acc + longint'(2048)) >>> 12;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    function automatic logic [127:0] rand_bus();
        logic [127:0] r;
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 4))
                0:       r[16*k +: 16] = 16'h7FFF;
                1:       r[16*k +: 16] = 16'h8000;
                2:       r[16*k +: 16] = 16'h0000;
                3:       r[16*k +: 16] = 16'($urandom_range(0, 511)) - 16'd256;
                default: r[16*k +: 16] = 16'($urandom);
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected result, exactly on its due cycle.
    always @(negedge clk) begin
        if (rst_N) begin
            for (int d = 0; d < N_DUT; d++) begin
                if (yv_w[d]) begin
                    if (sb_q[d].size() == 0) begin
                        ncmp++;
                        nmis++;
                        $display("FAIL dut%0d unexpected strobe: Y_ADDR 0x%0h, no result pending (cycle %0d)",
                                 d, ya_w[d], cyc);
                    end else begin
                        mon_e = sb_q[d].pop_front();
                        check($sformatf("dut%0d strobe cycle", d), cyc, mon_e.due);
                        check($sformatf("dut%0d Y", d), y_w[d], mon_e.y);
                        check($sformatf("dut%0d Y_ADDR", d), ya_w[d], mon_e.addr);
                    end
                end else if (sb_q[d].size() > 0 && sb_q[d][0].due <= cyc) begin
                    mon_e = sb_q[d].pop_front();
                    ncmp++;
                    nmis++;
                    $display("FAIL dut%0d missing strobe: no Y_VALID, required at cycle %0d for addr 0x%0h",
                             d, mon_e.due, mon_e.addr);
                end
            end
        end
    end

    // Drive one cycle of input; the model decides capture vs. overrun from sample timing alone.
    task automatic apply(input logic [127:0] x, input logic [5:0] a);
        int   e_n;
        exp_t e;
        e_n     = cyc + 1;
        xstate  = x;
        addr_in = a;
        if (a != prev) begin
            if (e_n >= last_cap + 3) begin
                last_cap = e_n;
                for (int d = 0; d < N_DUT; d++) begin
                    e.y    = ref_y(wsel(d), x);
                    e.addr = a;
                    e.due  = e_n + 3;
                    sb_q[d].push_back(e);
                end
            end else begin
                ovr_exp = 1'b1;
            end
        end
        prev = a;
        @(posedge clk);
        #1;
        vectors++;
    endtask

    task automatic hold(input int n);
        repeat (n) apply(rand_bus(), prev);
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < N_DUT; d++) begin
            check($sformatf("%s dut%0d Y", tag, d), y_w[d], 0);
            check($sformatf("%s dut%0d Y_VALID", tag, d), yv_w[d], 0);
            check($sformatf("%s dut%0d Y_ADDR", tag, d), ya_w[d], 0);
            check($sformatf("%s dut%0d OVERRUN", tag, d), ovr_w[d], 0);
        end
    endtask

    task automatic chk_ovr(input string tag);
        for (int d = 0; d < N_DUT; d++) begin
            check($sformatf("%s dut%0d OVERRUN", tag, d), ovr_w[d], ovr_exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst_N    = 1'b0;
        for (int d = 0; d < N_DUT; d++) sb_q[d].delete();
        prev     = '0;
        last_cap = -100;
        ovr_exp  = 1'b0;
        #1;
        chk_zero("reset async");
        repeat (n) begin
            xstate  = rand_bus();
            addr_in = 6'($urandom);
            @(posedge clk);
            #1;
            vectors++;
            chk_zero("reset held");
        end
        addr_in = '0;
        xstate  = rand_bus();
        rst_N   = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        xstate  = '0;
        addr_in = '0;
        @(posedge clk);
        #1;
        do_reset(3);
        hold(6);
        chk_zero("idle after reset");

        apply({8{16'h0100}}, 6'd1);
        hold(5);
        check("basic Y", y_w[0], 16'h0800);
        check("basic Y_ADDR", ya_w[0], 6'd1);

        apply({112'h0, 16'h0001}, 6'd2);
        hold(5);
        check("round up Y", y_w[1], 16'h0001);
        check("round down Y", y_w[2], 16'h0000);

        apply({8{16'h7FFF}}, 6'd3);
        hold(5);
        check("sat pos Y", y_w[3], 16'h7FFF);
        apply({8{16'h8000}}, 6'd4);
        hold(5);
        check("sat neg Y", y_w[3], 16'h8000);
        chk_ovr("directed");

        apply(rand_bus(), 6'd62);
        hold(3);
        apply(rand_bus(), 6'd63);
        hold(3);
        apply(rand_bus(), 6'd0);
        hold(6);
        check("wrap Y_ADDR", ya_w[0], 6'd0);
        chk_ovr("stream");

        apply(rand_bus(), 6'd10);
        apply(rand_bus(), 6'd10);
        apply(rand_bus(), 6'd11);
        hold(6);
        check("overrun flag", ovr_w[0], 1'b1);
        check("overrun Y_ADDR", ya_w[0], 6'd10);
        chk_ovr("overrun");

        apply(rand_bus(), 6'd20);
        do_reset(2);
        hold(8);
        chk_zero("after mid-MAC reset");

        for (int i = 0; i < 400; i++) begin
            apply(rand_bus(), 6'($urandom));
            hold($urandom_range(0, 5));
            chk_ovr("random");
            if ($urandom_range(0, 49) == 0) begin
                do_reset($urandom_range(1, 3));
                hold(2);
            end
        end

        hold(8);
        for (int d = 0; d < N_DUT; d++) begin
            check($sformatf("dut%0d pending results", d), sb_q[d].size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, nmis);
        $finish;
    end

endmodule
